ssd_capture: RTL

Scanning seven-segment capture block: the receiving end of the multiplexed display bus driven by the stopwatch's segment decoders. It watches a segment bus plus one-hot digit strobes, requires each pattern to be stable before accepting it, maps the pattern back to a hex nibble, and publishes a complete multi-digit value once every digit has been seen. It is used for display loop-back checking and for readback into the status path.

---
 rtl/ssd_capture_if.sv | 40 ++++
 rtl/ssd_capture.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ssd_capture_if.sv
// ssd_capture_if: bundles the multiplexed seven-segment bus with the
// captured-frame outputs of ssd_capture.
// The err_cnt signal exists only when SSD_CAPTURE_ERRCNT_EN is defined.
interface ssd_capture_if #(
    parameter int NDIG = 4
);
    logic [6:0]        seg_in;
    logic [NDIG-1:0]   dig_sel;
    logic [4*NDIG-1:0] value;
    logic [NDIG-1:0]   blank;
    logic              frame_valid;
    logic              frame_err;
`ifdef SSD_CAPTURE_ERRCNT_EN
    logic [7:0]        err_cnt;

    // Display driver side: drives the scan bus, observes captured frames.
    modport master (
        output seg_in, dig_sel,
        input  value, blank, frame_valid, frame_err, err_cnt
    );

    // Capture side.
    modport slave (
        input  seg_in, dig_sel,
        output value, blank, frame_valid, frame_err, err_cnt
    );
`else
    // Display driver side: drives the scan bus, observes captured frames.
    modport master (
        output seg_in, dig_sel,
        input  value, blank, frame_valid, frame_err
    );

    // Capture side.
    modport slave (
        input  seg_in, dig_sel,
        output value, blank, frame_valid, frame_err
    );
`endif
endinterface

// File: rtl/ssd_capture.sv
// ssd_capture: receiving end of a multiplexed seven-segment display bus.
// A slot FSM waits for {dig_sel, seg_in} to stay stable for STABLE_CYC cycles.
// The accepted pattern is decoded back to a hex nibble and written into a
// per-digit shadow slot. Once every digit has been seen, the shadow is
// published as one frame.
// Optional feature: define SSD_CAPTURE_ERRCNT_EN to add a saturating 8-bit
// count of captured unrecognized patterns (bus.err_cnt).
module ssd_capture #(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic         clk,
    input  logic         rst,
    ssd_capture_if.slave bus
);

    localparam int CW = $clog2(STABLE_CYC + 1);
    localparam int LW = NDIG + 7;
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_STABLE = CW'(STABLE_CYC);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        LOCKED
    } state_t;

    state_t               state, state_nxt;
    logic [LW-1:0]        lat, lat_nxt, cur;
    logic [CW-1:0]        cnt, cnt_nxt, cnt_inc;
    logic                 onehot;
    logic                 cap;

    logic [3:0]           dec_nib;
    logic                 dec_blank;
    logic                 dec_err;

    logic [NDIG-1:0][3:0] sh_nib;
    logic [NDIG-1:0]      sh_blank;
    logic [NDIG-1:0]      sh_err;
    logic [NDIG-1:0]      seen;
    logic                 frame_done;

    assign cur     = {bus.dig_sel, bus.seg_in};
    assign cnt_inc = cnt + CNT_ONE;
    assign onehot  = (bus.dig_sel != '0) &&
                     ((bus.dig_sel & (bus.dig_sel - NDIG'(1))) == '0);

    // A frame is ready as soon as every digit has at least one capture.
    assign frame_done = &seen;

    // Map a segment pattern back to its nibble; all-off is blank, anything else
    // outside the table is an error (nibble 0 in both cases).
    always_comb begin
        dec_nib   = 4'h0;
        dec_blank = 1'b0;
        dec_err   = 1'b0;
        case (bus.seg_in)
            7'b0111111: dec_nib = 4'h0;
            7'b0000110: dec_nib = 4'h1;
            7'b1011011: dec_nib = 4'h2;
            7'b1001111: dec_nib = 4'h3;
            7'b1100110: dec_nib = 4'h4;
            7'b1101101: dec_nib = 4'h5;
            7'b1111101: dec_nib = 4'h6;
            7'b0000111: dec_nib = 4'h7;
            7'b1111111: dec_nib = 4'h8;
            7'b1101111: dec_nib = 4'h9;
            7'b1110111: dec_nib = 4'hA;
            7'b1111100: dec_nib = 4'hB;
            7'b0111001: dec_nib = 4'hC;
            7'b1011110: dec_nib = 4'hD;
            7'b1111001: dec_nib = 4'hE;
            7'b1110001: dec_nib = 4'hF;
            7'b0000000: dec_blank = 1'b1;
            default:    dec_err   = 1'b1;
        endcase
    end

    // Slot FSM state, latched input snapshot and stability counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            lat   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            lat   <= lat_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic. Any change of the snapshot restarts the count at 1.
    // The count reaching STABLE_CYC captures and locks. When STABLE_CYC is 1,
    // this means a capture on the very first cycle of a new pattern.
    always_comb begin
        state_nxt = state;
        lat_nxt   = lat;
        cnt_nxt   = cnt;
        cap       = 1'b0;
        if (!onehot) begin
            state_nxt = IDLE;
        end else if (state == IDLE || cur != lat) begin
            lat_nxt = cur;
            cnt_nxt = CNT_ONE;
            if (CNT_ONE == CNT_STABLE) begin
                cap       = 1'b1;
                state_nxt = LOCKED;
            end else begin
                state_nxt = SETTLE;
            end
        end else if (state == SETTLE) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == CNT_STABLE) begin
                cap       = 1'b1;
                state_nxt = LOCKED;
            end
        end
        // In LOCKED with unchanged inputs the counter holds at STABLE_CYC.
    end

    // Shadow slots. A capture in the same cycle as frame completion wins
    // over the clear, so that digit already counts toward the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_nib   <= '0;
            sh_blank <= '0;
            sh_err   <= '0;
            seen     <= '0;
        end else begin
            for (int i = 0; i < NDIG; i++) begin
                if (cap && bus.dig_sel[i]) begin
                    sh_nib[i]   <= dec_nib;
                    sh_blank[i] <= dec_blank;
                    sh_err[i]   <= dec_err;
                    seen[i]     <= 1'b1;
                end else if (frame_done) begin
                    sh_err[i] <= 1'b0;
                    seen[i]   <= 1'b0;
                end
            end
        end
    end

    // Publish a completed frame. The outputs hold their values between frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.value       <= '0;
            bus.blank       <= '0;
            bus.frame_err   <= 1'b0;
            bus.frame_valid <= 1'b0;
        end else begin
            bus.frame_valid <= frame_done;
            if (frame_done) begin
                bus.value     <= sh_nib;
                bus.blank     <= sh_blank;
                bus.frame_err <= |sh_err;
            end
        end
    end

`ifdef SSD_CAPTURE_ERRCNT_EN
    // Saturating count of captured unrecognized patterns. Only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.err_cnt <= 8'd0;
        end else if (cap && dec_err && bus.err_cnt != 8'hFF) begin
            bus.err_cnt <= bus.err_cnt + 8'd1;
        end
    end
`endif

endmodule
